// File: rtl/fifo_stream_pkg.sv
// Shared defaults and width helpers for the FIFO read-side stream stage.
package fifo_stream_pkg;

    localparam int unsigned WIDTH_DEF     = 32;
    localparam int unsigned BURST_LEN_DEF = 16;
    localparam int unsigned BUF_DEPTH_DEF = 4;
    localparam int unsigned PKT_CNT_W_DEF = 16;

    // Bits needed to index n entries (0..n-1), never less than one.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 32'd1);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// Register-based circular buffer; pointers wrap by compare-to-max so any depth works.
module stream_buf
    import fifo_stream_pkg::*;
#(
    parameter  int unsigned WIDTH = WIDTH_DEF,
    parameter  int unsigned DEPTH = BUF_DEPTH_DEF,
    localparam int unsigned PTR_W = idx_w(DEPTH),
    localparam int unsigned OCC_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [OCC_W-1:0] o_occ
);

    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1'b1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_ONE;
    endfunction

    // Entry storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end else begin
            r_mem <= r_mem;
        end
    end

    // Write/read pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            r_wr_ptr <= i_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
            r_rd_ptr <= i_pop  ? ptr_inc(r_rd_ptr) : r_rd_ptr;
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO onto a valid/ready stream, absorbing the FIFO's
// one-cycle read latency and framing packets of BURST_LEN words.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned BURST_LEN = BURST_LEN_DEF,
    parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int unsigned PKT_CNT_W = PKT_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_dout,
    output logic                 fifo_r_enb,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_last,
    output logic [PKT_CNT_W-1:0] pkt_count,
    output logic                 busy
);

    localparam int unsigned OCC_W  = cnt_w(BUF_DEPTH);
    localparam int unsigned BEAT_W = idx_w(BURST_LEN);

    localparam logic [OCC_W:0]     ISSUE_LIM = (OCC_W + 1)'(BUF_DEPTH - 1);
    localparam logic [BEAT_W-1:0]  BEAT_MAX  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0]  BEAT_ONE  = BEAT_W'(1'b1);
    localparam logic [PKT_CNT_W-1:0] PKT_ONE = PKT_CNT_W'(1'b1);

    logic                 r_rd_q;
    logic [BEAT_W-1:0]    r_beat;
    logic [PKT_CNT_W-1:0] r_pkt_count;

    logic [OCC_W-1:0]     w_occ;
    logic [WIDTH-1:0]     w_head;
    logic [OCC_W:0]       w_pending;
    logic                 w_issue;
    logic                 w_valid;
    logic                 w_last;
    logic                 w_xfer;

    stream_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_push      (r_rd_q),
        .i_push_data (fifo_dout),
        .i_pop       (w_xfer),
        .o_head      (w_head),
        .o_occ       (w_occ)
    );

    // Words already buffered plus the one in flight; a same-cycle pop is ignored.
    assign w_pending = {1'b0, w_occ} + (OCC_W + 1)'(r_rd_q);

    // Read issue and stream status decode.
    always_comb begin
        w_issue = 1'b0;
        w_valid = 1'b0;
        w_last  = 1'b0;
        w_xfer  = 1'b0;
        if (en && !fifo_empty && (w_pending <= ISSUE_LIM)) begin
            w_issue = 1'b1;
        end else begin
            w_issue = 1'b0;
        end
        w_valid = (w_occ != '0);
        w_last  = w_valid && (r_beat == BEAT_MAX);
        w_xfer  = w_valid && m_ready;
    end

    // Read-latency tracker, beat position and completed-packet counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_q      <= 1'b0;
            r_beat      <= '0;
            r_pkt_count <= '0;
        end else begin
            r_rd_q <= w_issue;
            if (w_xfer) begin
                r_beat      <= w_last ? '0 : r_beat + BEAT_ONE;
                r_pkt_count <= w_last ? r_pkt_count + PKT_ONE : r_pkt_count;
            end else begin
                r_beat      <= r_beat;
                r_pkt_count <= r_pkt_count;
            end
        end
    end

    assign fifo_r_enb = w_issue;
    assign m_valid    = w_valid;
    assign m_data     = w_head;
    assign m_last     = w_last;
    assign pkt_count  = r_pkt_count;
    assign busy       = r_rd_q | w_valid;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: a FIFO model feeds the reader, expected words are queued on write
// and a negedge monitor compares every accepted word, packet count and hold stability.
module tb_fifo_stream_reader;

    localparam int WIDTH     = 32;
    localparam int BURST_LEN = 16;
    localparam int BUF_DEPTH = 4;
    localparam int PKT_CNT_W = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 en = 1'b0;
    logic                 m_ready = 1'b0;
    logic                 fifo_empty;
    logic [WIDTH-1:0]     fifo_dout;
    logic                 fifo_r_enb;
    logic                 m_valid;
    logic [WIDTH-1:0]     m_data;
    logic                 m_last;
    logic [PKT_CNT_W-1:0] pkt_count;
    logic                 busy;

    int n_checks = 0;
    int n_fails  = 0;

    // FIFO model: stimulus advances fifo_wr, the read port advances fifo_rd.
    logic [WIDTH-1:0] fifo_mem [1024];
    int fifo_wr = 0;
    int fifo_rd = 0;
    assign fifo_empty = (fifo_wr == fifo_rd);

    // Reference: every written word comes out in order, last on every BURST_LEN-th.
    logic [WIDTH:0] exp_q [$];
    int ordinal  = 0;
    int exp_pkts = 0;

    logic           prev_stall = 1'b0;
    logic [WIDTH:0] prev_word  = '0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .WIDTH     (WIDTH),
        .BURST_LEN (BURST_LEN),
        .BUF_DEPTH (BUF_DEPTH),
        .PKT_CNT_W (PKT_CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_r_enb (fifo_r_enb),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .pkt_count  (pkt_count),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_rd   <= fifo_wr;
            fifo_dout <= '0;
        end else if (fifo_r_enb) begin
            fifo_dout <= fifo_mem[fifo_rd % 1024];
            fifo_rd   <= fifo_rd + 1;
        end
    end

    // Monitor: scoreboard pop on each transfer, hold check while stalled.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (reset) begin
            exp_q.delete();
            exp_pkts   = 0;
            prev_stall = 1'b0;
        end else begin
            check("rd_while_empty", 64'(fifo_r_enb & fifo_empty), 64'd0);
            check("pkt_count", 64'(pkt_count), 64'(exp_pkts));
            if (prev_stall) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_word", 64'({m_last, m_data}), 64'(prev_word));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(m_data), 64'hDEAD_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", 64'(m_data), 64'(e[WIDTH-1:0]));
                    check("m_last", 64'(m_last), 64'(e[WIDTH]));
                    if (e[WIDTH]) exp_pkts = exp_pkts + 1;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_last, m_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_write(input logic [WIDTH-1:0] d);
        fifo_mem[fifo_wr % 1024] = d;
        fifo_wr = fifo_wr + 1;
        exp_q.push_back({((ordinal % BURST_LEN) == BURST_LEN - 1), d});
        ordinal = ordinal + 1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        ordinal = 0;
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while (!(exp_q.size() == 0 && !busy && fifo_empty) && cyc < 600) begin
            tick();
            cyc++;
        end
        check(name, 64'(exp_q.size() == 0 && !busy && fifo_empty), 64'd1);
    endtask

    initial begin
        int found;
        int start_rd;
        int pushed;

        // Reset state
        repeat (2) tick();
        check("rst_r_enb", 64'(fifo_r_enb), 64'd0);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_data", 64'(m_data), 64'd0);
        check("rst_last", 64'(m_last), 64'd0);
        check("rst_pkt", 64'(pkt_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();

        // 1: single word latency
        m_ready = 1'b1;
        en      = 1'b1;
        fifo_write(32'hAABBCCDD);
        #1;
        check("t1_issue", 64'(fifo_r_enb), 64'd1);
        tick();
        check("t1_single_pulse", 64'(fifo_r_enb), 64'd0);
        check("t1_valid_n1", 64'(m_valid), 64'd0);
        tick();
        check("t1_valid_n2", 64'(m_valid), 64'd1);
        check("t1_data_n2", 64'(m_data), 64'hAABBCCDD);
        tick();
        check("t1_busy_idle", 64'(busy), 64'd0);

        // 2: 48-word framing at full throughput
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 48; i++) fifo_write(32'(i));
        en = 1'b1;
        found = 0;
        for (int c = 0; c < 6 && found == 0; c++) begin
            tick();
            if (m_valid) found = 1;
        end
        check("t2_first_valid", 64'(found), 64'd1);
        for (int i = 1; i < 48; i++) begin
            tick();
            check("t2_no_bubble", 64'(m_valid), 64'd1);
        end
        tick();
        check("t2_pkt_count", 64'(pkt_count), 64'd3);
        check("t2_busy_idle", 64'(busy), 64'd0);

        // 3: backpressure
        m_ready = 1'b0;
        en      = 1'b0;
        for (int i = 0; i < 10; i++) fifo_write($urandom);
        start_rd = fifo_rd;
        en = 1'b1;
        repeat (20) tick();
        check("t3_reads_bounded", 64'((fifo_rd - start_rd) <= BUF_DEPTH), 64'd1);
        check("t3_buf_full", 64'(fifo_rd - start_rd), 64'(BUF_DEPTH));
        check("t3_valid_held", 64'(m_valid), 64'd1);
        m_ready = 1'b1;
        wait_drain("t3_drain");

        // 4: underflow guard
        for (int i = 0; i < 50; i++) begin
            tick();
            check("t4_no_read", 64'(fifo_r_enb), 64'd0);
            check("t4_no_valid", 64'(m_valid), 64'd0);
        end
        fifo_write($urandom);
        found = 0;
        for (int c = 0; c < 3 && found == 0; c++) begin
            tick();
            if (m_valid) found = 1;
        end
        check("t4_latency", 64'(found), 64'd1);
        wait_drain("t4_drain");

        // 5: en gap mid-packet
        do_reset();
        en = 1'b0;
        for (int i = 0; i < 16; i++) fifo_write(32'h5000 + 32'(i));
        en = 1'b1;
        for (int c = 0; c < 20 && fifo_rd < start_rd + 1000 && (fifo_rd - (fifo_wr - 16)) < 6; c++) tick();
        en = 1'b0;
        check("t5_reads_before_gap", 64'(fifo_rd - (fifo_wr - 16)), 64'd6);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_no_read_gap", 64'(fifo_r_enb), 64'd0);
        end
        check("t5_drained", 64'(m_valid), 64'd0);
        check("t5_left_in_fifo", 64'(fifo_wr - fifo_rd), 64'd10);
        en = 1'b1;
        wait_drain("t5_drain");
        check("t5_pkt_count", 64'(pkt_count), 64'd1);

        // 6: asynchronous reset with three words buffered
        m_ready = 1'b0;
        en      = 1'b0;
        for (int i = 0; i < 3; i++) fifo_write($urandom);
        en = 1'b1;
        repeat (5) tick();
        check("t6_pre_valid", 64'(m_valid), 64'd1);
        check("t6_pre_pkt", 64'(pkt_count), 64'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_valid_clr", 64'(m_valid), 64'd0);
        check("t6_last_clr", 64'(m_last), 64'd0);
        check("t6_pkt_clr", 64'(pkt_count), 64'd0);
        check("t6_busy_clr", 64'(busy), 64'd0);
        tick();
        tick();
        reset   = 1'b0;
        ordinal = 0;
        m_ready = 1'b1;
        fifo_write(32'h12345678);
        wait_drain("t6_drain");

        // 7: random traffic with random backpressure and en gaps
        pushed = 0;
        for (int c = 0; c < 3000 && pushed < 200; c++) begin
            if ($urandom_range(0, 2) != 0) begin
                fifo_write($urandom);
                pushed++;
            end
            m_ready = ($urandom_range(0, 3) != 0);
            en      = ($urandom_range(0, 7) != 0);
            tick();
        end
        en      = 1'b1;
        m_ready = 1'b1;
        wait_drain("t7_drain");
        check("t7_pkt_count", 64'(pkt_count), 64'(exp_pkts));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
